// File: rtl/parking_gate_ctrl.sv
// ---------------------------------------------------------------------------
// parking_gate_ctrl
//   Supervisory controller for the car park.  It takes one-cycle "car passed"
//   ticks from the entry and exit direction detectors, sequences the entry
//   barrier (IDLE -> OPEN -> WAIT), and keeps a two-digit BCD occupancy count
//   that drives the decimal display.  Entry is refused while the park is full,
//   and count anomalies (tailgate, overflow, underflow) raise a sticky error.
//
// Parameters
//   CAPACITY    maximum number of cars, 1..99 (decimal)
//   OPEN_TICKS  barrier open timeout in clk cycles, >= 2
//   TW          timer width, 2**TW > OPEN_TICKS
//
// Ports
//   clk           in   rising-edge system clock
//   reset         in   asynchronous, active-high
//   entry_req     in   level, car waiting at the entry barrier
//   entry_tick    in   1-cycle pulse, car completed entry crossing
//   exit_tick     in   1-cycle pulse, car completed exit crossing
//   barrier_open  out  registered, 1 = entry barrier raised
//   occ_tens      out  registered BCD tens digit of occupancy
//   occ_ones      out  registered BCD ones digit of occupancy
//   full          out  occupancy == CAPACITY
//   empty         out  occupancy == 0
//   timeout       out  1-cycle pulse, barrier closed by timer with no entry
//   err_flag      out  sticky, tailgate / overflow / underflow seen
// ---------------------------------------------------------------------------
module parking_gate_ctrl #(
    parameter int CAPACITY   = 25,
    parameter int OPEN_TICKS = 50_000_000,
    parameter int TW         = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       entry_tick,
    input  logic       exit_tick,
    output logic       barrier_open,
    output logic [3:0] occ_tens,
    output logic [3:0] occ_ones,
    output logic       full,
    output logic       empty,
    output logic       timeout,
    output logic       err_flag
);

    localparam logic [3:0]    CAP_TENS   = 4'(CAPACITY / 10);
    localparam logic [3:0]    CAP_ONES   = 4'(CAPACITY % 10);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(OPEN_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OPEN = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          timeout_nxt;

    logic [7:0]    occ_nxt;
    logic          err_nxt;
    logic          car_in;
    logic          car_out;

    // BCD increment: ones 9 -> 0 carries into tens.  Callers never increment
    // past CAPACITY (<= 99), so the tens digit stays within 0..9.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
        if (ones == 4'd9)
            return {tens + 4'd1, 4'd0};
        else
            return {tens, ones + 4'd1};
    endfunction

    // BCD decrement: ones 0 -> 9 borrows from tens.  Callers never decrement 00.
    function automatic logic [7:0] bcd_dec(input logic [3:0] tens, input logic [3:0] ones);
        if (ones == 4'd0)
            return {tens - 4'd1, 4'd9};
        else
            return {tens, ones - 4'd1};
    endfunction

    // Decoded from the registered digits so they move together with the display.
    assign full  = (occ_tens == CAP_TENS) && (occ_ones == CAP_ONES);
    assign empty = (occ_tens == 4'd0) && (occ_ones == 4'd0);

    // Barrier sequencing.  WAIT keeps the barrier down until the requesting car
    // releases entry_req, so one waiting car cannot reopen it.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        timeout_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (entry_req && !full) begin
                    state_nxt = ST_OPEN;
                    timer_nxt = TIMER_LOAD;
                end
            end
            ST_OPEN: begin
                if (timer != '0)
                    timer_nxt = timer - TW'(1);
                // A car crossing on the last timer cycle wins over the timeout.
                if (entry_tick) begin
                    state_nxt = ST_WAIT;
                end else if (timer == '0) begin
                    state_nxt   = ST_WAIT;
                    timeout_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!entry_req)
                    state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // Occupancy update.  Simultaneous entry and exit ticks cancel out.
    always_comb begin
        car_in  = entry_tick && !exit_tick;
        car_out = exit_tick && !entry_tick;
        occ_nxt = {occ_tens, occ_ones};
        err_nxt = err_flag;
        if (car_in) begin
            if (full)
                err_nxt = 1'b1;
            else
                occ_nxt = bcd_inc(occ_tens, occ_ones);
            // Tailgate: a car got in without the barrier being sequenced open.
            if (state != ST_OPEN)
                err_nxt = 1'b1;
        end
        if (car_out) begin
            if (empty)
                err_nxt = 1'b1;
            else
                occ_nxt = bcd_dec(occ_tens, occ_ones);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            timer        <= '0;
            barrier_open <= 1'b0;
            timeout      <= 1'b0;
            occ_tens     <= 4'd0;
            occ_ones     <= 4'd0;
            err_flag     <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            // One cycle behind the FSM: raised the cycle after entering OPEN,
            // lowered the cycle after leaving it.
            barrier_open <= (state == ST_OPEN);
            timeout      <= timeout_nxt;
            occ_tens     <= occ_nxt[7:4];
            occ_ones     <= occ_nxt[3:0];
            err_flag     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_parking_gate_ctrl
//   Scoreboard bench for parking_gate_ctrl.  The driver applies one input
//   vector per clock, advances a behavioural model of the car park (integer
//   occupancy, integer countdown) and queues the outputs expected after the
//   next rising edge.  A monitor pops one entry per cycle and compares.
// ---------------------------------------------------------------------------
module tb_parking_gate_ctrl;

    localparam int CAP = 12;
    localparam int OT  = 4;
    localparam int TW  = 4;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       entry_req  = 1'b0;
    logic       entry_tick = 1'b0;
    logic       exit_tick  = 1'b0;
    logic       barrier_open;
    logic [3:0] occ_tens;
    logic [3:0] occ_ones;
    logic       full;
    logic       empty;
    logic       timeout;
    logic       err_flag;

    parking_gate_ctrl #(
        .CAPACITY   (CAP),
        .OPEN_TICKS (OT),
        .TW         (TW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .entry_req    (entry_req),
        .entry_tick   (entry_tick),
        .exit_tick    (exit_tick),
        .barrier_open (barrier_open),
        .occ_tens     (occ_tens),
        .occ_ones     (occ_ones),
        .full         (full),
        .empty        (empty),
        .timeout      (timeout),
        .err_flag     (err_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       bo;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       fu;
        logic       em;
        logic       to;
        logic       er;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  mon_e;
    int    n_vec  = 0;
    int    n_miss = 0;
    string phase  = "init";

    // Reference model: gate mode 0=idle, 1=open, 2=wait; cars as a plain integer.
    int m_mode;
    int m_left;
    int m_occ;
    bit m_err;

    task automatic model_reset();
        m_mode = 0;
        m_left = 0;
        m_occ  = 0;
        m_err  = 1'b0;
    endtask

    function automatic exp_t model_view(input bit bo, input bit to);
        exp_t e;
        e.bo   = bo;
        e.tens = 4'(m_occ / 10);
        e.ones = 4'(m_occ % 10);
        e.fu   = (m_occ == CAP);
        e.em   = (m_occ == 0);
        e.to   = to;
        e.er   = m_err;
        return e;
    endfunction

    task automatic check(input string tag, input exp_t e);
        exp_t act;
        act = {barrier_open, occ_tens, occ_ones, full, empty, timeout, err_flag};
        n_vec++;
        if (act !== e) begin
            n_miss++;
            $display("FAIL %s @%0t: got bo=%b occ=%h%h full=%b empty=%b to=%b err=%b, expected bo=%b occ=%h%h full=%b empty=%b to=%b err=%b",
                     tag, $time, act.bo, act.tens, act.ones, act.fu, act.em, act.to, act.er,
                     e.bo, e.tens, e.ones, e.fu, e.em, e.to, e.er);
        end
    endtask

    // One clock of stimulus; queues what the DUT should show after the next edge.
    task automatic cyc(input bit r, input bit req, input bit et, input bit xt);
        exp_t e;
        bit   was_open;
        bit   to;
        @(negedge clk);
        reset      = r;
        entry_req  = req;
        entry_tick = et;
        exit_tick  = xt;
        if (r) begin
            model_reset();
            e = model_view(1'b0, 1'b0);
        end else begin
            was_open = (m_mode == 1);
            to       = was_open && (m_left == 0) && !et;
            case (m_mode)
                0: if (req && m_occ != CAP) begin
                       m_mode = 1;
                       m_left = OT - 1;
                   end
                1: if (et || m_left == 0) m_mode = 2;
                   else m_left = m_left - 1;
                default: if (!req) m_mode = 0;
            endcase
            if (et && !xt) begin
                if (m_occ < CAP) m_occ = m_occ + 1;
                else             m_err = 1'b1;
                if (!was_open)   m_err = 1'b1;
            end
            if (xt && !et) begin
                if (m_occ > 0) m_occ = m_occ - 1;
                else           m_err = 1'b1;
            end
            e = model_view(was_open, to);
        end
        sb_q.push_back(e);
    endtask

    task automatic enter_car();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset asserted between edges must clear the outputs without a clock.
    task automatic async_reset_check();
        @(negedge clk);
        entry_req  = 1'b0;
        entry_tick = 1'b0;
        exit_tick  = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_reset", model_view(1'b0, 1'b0));
        sb_q.push_back(model_view(1'b0, 1'b0));
    endtask

    // Monitor: one expected entry per clock once stimulus starts.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check(phase, mon_e);
            end
        end
    end

    initial begin
        model_reset();
        phase = "reset";
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        phase = "entry_seq";
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        phase = "timeout";
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (7) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        phase = "bcd_carry";
        repeat (9) enter_car();
        phase = "bcd_borrow";
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b1);

        phase = "fill_full";
        repeat (CAP) enter_car();
        phase = "full_refuse";
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        phase = "overflow";
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        phase = "reset2";
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        phase = "net_zero";
        repeat (5) enter_car();
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        phase = "underflow";
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        phase = "reset3";
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        phase = "midop_reset";
        repeat (7) enter_car();
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        async_reset_check();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        phase = "resume";
        repeat (2) enter_car();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 249) == 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
